sdram_port_arbiter: RTL and testbench
=====================================

Name: sdram_port_arbiter

Overview:
- Shares the single SDRAM controller read/write request interface between NUM_PORTS independent requesters, e.g. video write, video read, DMA and CPU.
- Each port presents direction, address and burst length.
- The arbiter picks one port round-robin, drives the controller's wr/rd req/addr/burst and steers write data and read data.
- Sits between the per-port FIFO control logic and the SDRAM controller, all on the controller reference clock.

Parameters:
- NUM_PORTS, 4, number of requesters (2..8).
- ADDR_W, 24, SDRAM word address width.
- LEN_W, 10, burst length width.
- DATA_W, 16, data width.
- ACK_TIMEOUT, 1023, max cycles in ISSUE waiting for controller ack before abort.

Ports:
- clk  in  1  controller reference clock.
- rst  in  1  synchronous active-high reset.
- init_done  in  1  SDRAM init complete; no grants while low.
- port_req  in  NUM_PORTS  per-port request level.
- port_we  in  NUM_PORTS  1 = write burst, 0 = read burst.
- port_addr  in  NUM_PORTS*ADDR_W  packed start addresses.
- port_len  in  NUM_PORTS*LEN_W  packed burst lengths.
- port_wdata  in  NUM_PORTS*DATA_W  packed write data.
- port_grant  out  NUM_PORTS  one-hot, current owner.
- port_ack  out  NUM_PORTS  mirrors the controller ack for the owner only.
- port_done  out  NUM_PORTS  one-cycle pulse at end of burst.
- port_rdata  out  DATA_W  controller read data, broadcast.
- timeout_err  out  1  sticky, set on ack timeout.
- sdram_wr_req / sdram_rd_req  out  1  controller requests.
- sdram_wr_ack / sdram_rd_ack  in  1  controller acks, high for the whole burst.
- sdram_addr_o  out  ADDR_W  start address to controller.
- sdram_len_o  out  LEN_W  burst length to controller.
- sdram_din  out  DATA_W  write data to controller.
- sdram_dout  in  DATA_W  read data from controller.

Behaviour:
- Reset: state IDLE; pointer = port 0 highest priority. All outputs 0, including timeout_err.
- The reset takes effect on the next clk edge even mid-burst. The controller burst in flight is not aborted; rst is global.
- States: IDLE, ISSUE, XFER, DONE.
- IDLE:
  - If init_done=1 and any port_req is set, select the first requesting port at or after the pointer (wrapping).
  - Register grant, we, addr and len. Go to ISSUE.
  - Latency: req seen at edge n gives grant and sdram_*_req high from edge n+1.
- ISSUE:
  - Hold sdram_wr_req (we=1) or sdram_rd_req (we=0) high. Address and length are held stable from registers.
  - On ack=1 for the selected direction: drop req the same cycle (combinational from state) and go to XFER.
  - If the wait counter reaches ACK_TIMEOUT: drop req, set timeout_err, go to DONE.
- XFER:
  - port_ack[owner] = ack.
  - sdram_din = port_wdata[owner], combinational mux from registered grant.
  - Ack falling (1 to 0) goes to DONE.
- DONE:
  - One cycle: port_done[owner]=1.
  - Pointer = owner+1 modulo NUM_PORTS; clear grant; go to IDLE.
  - Minimum 1 idle cycle between bursts.
- Ack of the wrong direction in ISSUE or XFER is ignored.
- port_req dropped after grant: the burst still completes; requesters must hold req until done.
- Dropped before IDLE sampling: not selected.
- Simultaneous requests: round-robin only; read and write have equal priority.
- init_done falling: no effect on the current burst; blocks new grants.
- port_rdata = sdram_dout always. Requesters qualify it with port_ack and their own we=0.
- Wait counter width = clog2(ACK_TIMEOUT+1). It is cleared on entry to ISSUE and saturates.

Decomposition:
- Package sdram_arb_pkg:
  - state encoding localparams: IDLE, ISSUE, XFER, DONE.
  - default widths.
  - clog2 function.
- Sub-module rr_picker: combinational round-robin priority encoder.
  - Inputs: req vector and pointer.
  - Outputs: one-hot grant and index.
  - Instantiated once.

Test Plan:
1. Reset then init_done=1; port 2 write, addr 0x000100, len 256 -> grant=0100 next cycle, sdram_wr_req=1, addr_o=0x000100, len_o=256. Ack high 256 cycles -> port_done[2] pulse one cycle after ack falls.
2. All 4 ports request continuously -> grant order 0,1,2,3,0. Each separated by ≥1 IDLE cycle; no port is granted twice before the others.
3. Port 1 read while init_done=0 -> no grant. init_done raised -> grant within 1 cycle; port_ack[1] tracks sdram_rd_ack; other port_ack stay 0.
4. Ack never arrives with ACK_TIMEOUT=15 -> req deasserts after 15 ISSUE cycles, timeout_err=1 and stays 1, arbiter serves the next port.
5. rst asserted mid-XFER -> next edge: all outputs 0, grant cleared, pointer=0. After release, port 3 and port 0 both request -> port 0 is granted.
6. Port 0 write in flight while stray sdram_rd_ack pulses -> ignored; burst completes only on sdram_wr_ack falling.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared constants for the SDRAM port arbiter: FSM state codes,
// default widths and a constant-evaluable clog2.
package sdram_arb_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] XFER  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam int DEF_NUM_PORTS   = 4;
    localparam int DEF_ADDR_W      = 24;
    localparam int DEF_LEN_W       = 10;
    localparam int DEF_DATA_W      = 16;
    localparam int DEF_ACK_TIMEOUT = 1023;

    // Smallest r with 2**r >= value; usable in parameter expressions.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sdram_port_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: returns the first
// requesting port at or after ptr, wrapping past the last port.
module rr_picker
    import sdram_arb_pkg::*;
#(
    parameter int NUM_PORTS = DEF_NUM_PORTS,
    parameter int IDX_W     = clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic                 valid,
    output logic [NUM_PORTS-1:0] grant,
    output logic [IDX_W-1:0]     idx
);

    localparam logic [IDX_W:0] N_EXT = (IDX_W + 1)'(NUM_PORTS);

    // slot gi is the port visited gi places after the pointer
    logic [IDX_W-1:0]     slot_idx [NUM_PORTS];
    logic [NUM_PORTS-1:0] slot_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_slot
            logic [IDX_W:0] sum;
            assign sum          = {1'b0, ptr} + (IDX_W + 1)'(gi);
            assign slot_idx[gi] = (sum >= N_EXT) ? IDX_W'(sum - N_EXT) : sum[IDX_W-1:0];
            assign slot_hit[gi] = req[slot_idx[gi]];
            assign grant[gi]    = valid && (idx == IDX_W'(gi));
        end
    endgenerate

    // Scan from the farthest slot down so the nearest hit wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (slot_hit[i]) begin
                valid = 1'b1;
                idx   = slot_idx[i];
            end
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller request interface
// between NUM_PORTS burst requesters. One burst at a time:
// IDLE -> ISSUE (request until ack or timeout) -> XFER -> DONE.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_PORTS   = DEF_NUM_PORTS,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int LEN_W       = DEF_LEN_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        init_done,
    input  logic [NUM_PORTS-1:0]        port_req,
    input  logic [NUM_PORTS-1:0]        port_we,
    input  logic [NUM_PORTS*ADDR_W-1:0] port_addr,
    input  logic [NUM_PORTS*LEN_W-1:0]  port_len,
    input  logic [NUM_PORTS*DATA_W-1:0] port_wdata,
    output logic [NUM_PORTS-1:0]        port_grant,
    output logic [NUM_PORTS-1:0]        port_ack,
    output logic [NUM_PORTS-1:0]        port_done,
    output logic [DATA_W-1:0]           port_rdata,
    output logic                        timeout_err,
    output logic                        sdram_wr_req,
    output logic                        sdram_rd_req,
    input  logic                        sdram_wr_ack,
    input  logic                        sdram_rd_ack,
    output logic [ADDR_W-1:0]           sdram_addr_o,
    output logic [LEN_W-1:0]            sdram_len_o,
    output logic [DATA_W-1:0]           sdram_din,
    input  logic [DATA_W-1:0]           sdram_dout
);

    localparam int IDX_W  = clog2(NUM_PORTS);
    localparam int WAIT_W = clog2(ACK_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(ACK_TIMEOUT);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_PORTS - 1);

    logic [1:0]           state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [NUM_PORTS-1:0] grant_q, grant_d;
    logic                 we_q, we_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [WAIT_W-1:0]    wait_q, wait_d;
    logic                 timeout_err_q, timeout_err_d;

    logic                 pick_valid;
    logic [NUM_PORTS-1:0] pick_grant;
    logic [IDX_W-1:0]     pick_idx;

    // per-port views of the packed buses
    logic [ADDR_W-1:0] addr_arr  [NUM_PORTS];
    logic [LEN_W-1:0]  len_arr   [NUM_PORTS];
    logic [DATA_W-1:0] wdata_arr [NUM_PORTS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
            assign addr_arr[gi]  = port_addr[gi*ADDR_W +: ADDR_W];
            assign len_arr[gi]   = port_len[gi*LEN_W +: LEN_W];
            assign wdata_arr[gi] = port_wdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    rr_picker #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_picker (
        .req   (port_req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    // Only the ack matching the burst direction counts; the other is ignored.
    logic sel_ack;
    logic issuing;
    logic in_burst;
    assign sel_ack  = we_q ? sdram_wr_ack : sdram_rd_ack;
    assign in_burst = (state_q == ISSUE) || (state_q == XFER);
    assign issuing  = (state_q == ISSUE) && !sel_ack && (wait_q != WAIT_MAX);

    // Next-state logic for the burst FSM, pointer and captured request.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        owner_d       = owner_q;
        grant_d       = grant_q;
        we_d          = we_q;
        addr_d        = addr_q;
        len_d         = len_q;
        wait_d        = wait_q;
        timeout_err_d = timeout_err_q;
        case (state_q)
            IDLE: begin
                if (init_done && pick_valid) begin
                    state_d = ISSUE;
                    grant_d = pick_grant;
                    owner_d = pick_idx;
                    we_d    = port_we[pick_idx];
                    addr_d  = addr_arr[pick_idx];
                    len_d   = len_arr[pick_idx];
                    wait_d  = '0;
                end
            end
            ISSUE: begin
                if (sel_ack) begin
                    state_d = XFER;
                end else if (wait_q == WAIT_MAX) begin
                    state_d       = DONE;
                    timeout_err_d = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            XFER: begin
                if (!sel_ack) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                grant_d = '0;
                ptr_d   = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            owner_q       <= '0;
            grant_q       <= '0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            len_q         <= '0;
            wait_q        <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            owner_q       <= owner_d;
            grant_q       <= grant_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            len_q         <= len_d;
            wait_q        <= wait_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign port_grant   = grant_q;
    assign port_ack     = in_burst ? (grant_q & {NUM_PORTS{sel_ack}}) : '0;
    assign port_done    = (state_q == DONE) ? grant_q : '0;
    assign port_rdata   = sdram_dout;
    assign timeout_err  = timeout_err_q;
    assign sdram_wr_req = issuing && we_q;
    assign sdram_rd_req = issuing && !we_q;
    assign sdram_addr_o = addr_q;
    assign sdram_len_o  = len_q;
    assign sdram_din    = (|grant_q) ? wdata_arr[owner_q] : '0;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter (4 ports, ACK_TIMEOUT=15).
// Inputs change 2 time units after each rising edge; outputs are
// checked 1 unit later, well away from the next edge.
module tb_sdram_port_arbiter;

    logic        clk;
    logic        rst;
    logic        init_done;
    logic [3:0]  port_req;
    logic [3:0]  port_we;
    logic [95:0] port_addr;
    logic [39:0] port_len;
    logic [63:0] port_wdata;
    logic [3:0]  port_grant;
    logic [3:0]  port_ack;
    logic [3:0]  port_done;
    logic [15:0] port_rdata;
    logic        timeout_err;
    logic        sdram_wr_req;
    logic        sdram_rd_req;
    logic        sdram_wr_ack;
    logic        sdram_rd_ack;
    logic [23:0] sdram_addr_o;
    logic [9:0]  sdram_len_o;
    logic [15:0] sdram_din;
    logic [15:0] sdram_dout;

    int total = 0;
    int bad   = 0;

    sdram_port_arbiter #(
        .NUM_PORTS   (4),
        .ADDR_W      (24),
        .LEN_W       (10),
        .DATA_W      (16),
        .ACK_TIMEOUT (15)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .init_done    (init_done),
        .port_req     (port_req),
        .port_we      (port_we),
        .port_addr    (port_addr),
        .port_len     (port_len),
        .port_wdata   (port_wdata),
        .port_grant   (port_grant),
        .port_ack     (port_ack),
        .port_done    (port_done),
        .port_rdata   (port_rdata),
        .timeout_err  (timeout_err),
        .sdram_wr_req (sdram_wr_req),
        .sdram_rd_req (sdram_rd_req),
        .sdram_wr_ack (sdram_wr_ack),
        .sdram_rd_ack (sdram_rd_ack),
        .sdram_addr_o (sdram_addr_o),
        .sdram_len_o  (sdram_len_o),
        .sdram_din    (sdram_din),
        .sdram_dout   (sdram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total = total + 1;
        assert (obs === exp)
        else begin
            bad = bad + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [3:0] e;

    initial begin
        rst          = 1'b1;
        init_done    = 1'b0;
        port_req     = 4'b0000;
        port_we      = 4'b0000;
        port_addr    = {24'h000D00, 24'h000100, 24'h000B00, 24'h000A00};
        port_len     = {10'd7, 10'd256, 10'd5, 10'd4};
        port_wdata   = {16'hD333, 16'hC222, 16'hB111, 16'hA000};
        sdram_wr_ack = 1'b0;
        sdram_rd_ack = 1'b0;
        sdram_dout   = 16'h0000;

        // reset state
        step(); step();
        #1;
        chk("rst_grant", 64'(port_grant), 64'h0);
        chk("rst_wr_req", 64'(sdram_wr_req), 64'h0);
        chk("rst_rd_req", 64'(sdram_rd_req), 64'h0);
        chk("rst_done", 64'(port_done), 64'h0);
        chk("rst_timeout", 64'(timeout_err), 64'h0);
        chk("rst_addr", 64'(sdram_addr_o), 64'h0);
        chk("rst_din", 64'(sdram_din), 64'h0);
        rst = 1'b0;

        // 1: single write burst from port 2, 256 ack cycles
        step();
        init_done = 1'b1;
        port_we   = 4'b0100;
        port_req  = 4'b0100;
        #1;
        chk("t1_pre_grant", 64'(port_grant), 64'h0);
        step(); #1;
        chk("t1_grant", 64'(port_grant), 64'h4);
        chk("t1_wr_req", 64'(sdram_wr_req), 64'h1);
        chk("t1_rd_req", 64'(sdram_rd_req), 64'h0);
        chk("t1_addr", 64'(sdram_addr_o), 64'h000100);
        chk("t1_len", 64'(sdram_len_o), 64'd256);
        chk("t1_din", 64'(sdram_din), 64'hC222);
        step(); #1;
        chk("t1_wr_req_hold", 64'(sdram_wr_req), 64'h1);
        sdram_wr_ack = 1'b1;
        #1;
        chk("t1_req_drop", 64'(sdram_wr_req), 64'h0);
        chk("t1_ack", 64'(port_ack), 64'h4);
        for (int i = 0; i < 255; i++) step();
        #1;
        chk("t1_ack_late", 64'(port_ack), 64'h4);
        step();
        sdram_wr_ack = 1'b0;
        #1;
        chk("t1_ack_fall", 64'(port_ack), 64'h0);
        chk("t1_no_done_yet", 64'(port_done), 64'h0);
        step(); #1;
        chk("t1_done", 64'(port_done), 64'h4);
        port_req = 4'b0000;
        step(); #1;
        chk("t1_done_end", 64'(port_done), 64'h0);
        chk("t1_grant_clr", 64'(port_grant), 64'h0);

        // 2: all four ports read continuously -> 0,1,2,3,0
        rst = 1'b1;
        step();
        rst      = 1'b0;
        port_we  = 4'b0000;
        port_req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            e = 4'b0001 << (k % 4);
            #1;
            chk("t2_gap", 64'(port_grant), 64'h0);
            step(); #1;
            chk("t2_grant", 64'(port_grant), 64'(e));
            chk("t2_rd_req", 64'(sdram_rd_req), 64'h1);
            sdram_rd_ack = 1'b1;
            sdram_dout   = 16'h5A00 + 16'(k);
            #1;
            chk("t2_ack", 64'(port_ack), 64'(e));
            chk("t2_rdata", 64'(port_rdata), 64'h5A00 + 64'(k));
            step();
            step();
            sdram_rd_ack = 1'b0;
            step(); #1;
            chk("t2_done", 64'(port_done), 64'(e));
            step();
        end
        port_req = 4'b0000;

        // 3: port 1 read blocked until init_done
        init_done = 1'b0;
        port_req  = 4'b0010;
        step(); step(); #1;
        chk("t3_blocked_grant", 64'(port_grant), 64'h0);
        chk("t3_blocked_req", 64'(sdram_rd_req), 64'h0);
        init_done = 1'b1;
        step(); #1;
        chk("t3_grant", 64'(port_grant), 64'h2);
        chk("t3_rd_req", 64'(sdram_rd_req), 64'h1);
        chk("t3_addr", 64'(sdram_addr_o), 64'h000B00);
        sdram_rd_ack = 1'b1;
        sdram_dout   = 16'h1234;
        #1;
        chk("t3_ack", 64'(port_ack), 64'h2);
        chk("t3_rdata", 64'(port_rdata), 64'h1234);
        step(); #1;
        chk("t3_ack_xfer", 64'(port_ack), 64'h2);
        sdram_rd_ack = 1'b0;
        #1;
        chk("t3_ack_track", 64'(port_ack), 64'h0);
        step(); #1;
        chk("t3_done", 64'(port_done), 64'h2);
        port_req = 4'b0000;
        step();

        // 4: port 2 read never acked -> timeout, then port 3 served
        port_we  = 4'b1001;
        port_req = 4'b1100;
        step(); #1;
        chk("t4_grant", 64'(port_grant), 64'h4);
        chk("t4_rd_req_first", 64'(sdram_rd_req), 64'h1);
        for (int i = 0; i < 14; i++) step();
        #1;
        chk("t4_rd_req_15th", 64'(sdram_rd_req), 64'h1);
        step(); #1;
        chk("t4_rd_req_drop", 64'(sdram_rd_req), 64'h0);
        chk("t4_timeout_pre", 64'(timeout_err), 64'h0);
        step(); #1;
        chk("t4_timeout_set", 64'(timeout_err), 64'h1);
        chk("t4_done", 64'(port_done), 64'h4);
        port_req = 4'b1000;
        step(); #1;
        chk("t4_idle_grant", 64'(port_grant), 64'h0);
        chk("t4_timeout_sticky", 64'(timeout_err), 64'h1);
        step(); #1;
        chk("t4_next_grant", 64'(port_grant), 64'h8);
        chk("t4_wr_req", 64'(sdram_wr_req), 64'h1);
        sdram_wr_ack = 1'b1;
        #1;
        chk("t4_ack", 64'(port_ack), 64'h8);
        chk("t4_din", 64'(sdram_din), 64'hD333);
        step();

        // 5: reset in the middle of XFER
        rst = 1'b1;
        step(); #1;
        chk("t5_grant", 64'(port_grant), 64'h0);
        chk("t5_ack", 64'(port_ack), 64'h0);
        chk("t5_wr_req", 64'(sdram_wr_req), 64'h0);
        chk("t5_timeout", 64'(timeout_err), 64'h0);
        chk("t5_addr", 64'(sdram_addr_o), 64'h0);
        chk("t5_len", 64'(sdram_len_o), 64'h0);
        chk("t5_din", 64'(sdram_din), 64'h0);
        rst          = 1'b0;
        sdram_wr_ack = 1'b0;
        port_req     = 4'b1001;
        step(); #1;
        chk("t5_ptr0_grant", 64'(port_grant), 64'h1);
        chk("t5_wr_req_after", 64'(sdram_wr_req), 64'h1);

        // 6: stray read acks during a port 0 write are ignored
        sdram_rd_ack = 1'b1;
        #1;
        chk("t6_stray_req", 64'(sdram_wr_req), 64'h1);
        chk("t6_stray_ack", 64'(port_ack), 64'h0);
        step(); #1;
        chk("t6_still_issue", 64'(sdram_wr_req), 64'h1);
        sdram_rd_ack = 1'b0;
        sdram_wr_ack = 1'b1;
        #1;
        chk("t6_ack", 64'(port_ack), 64'h1);
        chk("t6_req_drop", 64'(sdram_wr_req), 64'h0);
        chk("t6_din", 64'(sdram_din), 64'hA000);
        step();
        sdram_rd_ack = 1'b1;
        #1;
        chk("t6_xfer_ack", 64'(port_ack), 64'h1);
        chk("t6_xfer_no_done", 64'(port_done), 64'h0);
        step(); #1;
        chk("t6_hold_grant", 64'(port_grant), 64'h1);
        chk("t6_hold_no_done", 64'(port_done), 64'h0);
        sdram_wr_ack = 1'b0;
        #1;
        chk("t6_ack_fall", 64'(port_ack), 64'h0);
        step(); #1;
        chk("t6_done", 64'(port_done), 64'h1);
        port_req     = 4'b1000;
        sdram_rd_ack = 1'b0;
        step(); #1;
        chk("t6_idle_grant", 64'(port_grant), 64'h0);
        chk("t6_idle_done", 64'(port_done), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
